// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 decoder scan driver.
// State encodings, select geometry and the counter-width helper live here.
package decoder_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] DRIVE = 2'd2;

  localparam int NUM_OUTPUTS = 8;
  localparam int SEL_W       = 3;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Width able to hold any reload value (at most max(div, blank) - 1), never below 1 bit.
  function automatic int cnt_width(input int div, input int blank);
    int m;
    m = max_int(div, blank);
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Generic down-counter: load a value, count down to zero and hold there.
// zero flags the final cycle of a timed interval that was loaded with (length - 1).
module cycle_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload has priority, otherwise decrement until zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/decoder_scan_driver.sv
// Scan driver for a downstream 3-to-8 decoder (e, a=MSB, b, c).
// Walks the eight outputs up or down, once or forever, with e held low for
// BLANK_CYCLES before every slot so the select never changes under an enabled decoder.
// Optional feature: define SCAN_SKIP_MASK_EN to add skip_mask, which suppresses e
// for masked slots while keeping slot timing unchanged.
module decoder_scan_driver
  import decoder_pkg::*;
#(
  parameter int DIV          = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SCAN_SKIP_MASK_EN
  input  logic [NUM_OUTPUTS-1:0] skip_mask,
`endif
  input  logic start,
  input  logic stop,
  input  logic dir,
  input  logic one_shot,
  output logic e,
  output logic a,
  output logic b,
  output logic c,
  output logic busy,
  output logic done
);

  localparam int CNT_W = cnt_width(DIV, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
  // Every slot starts in BLANK, or directly in DRIVE when there is no blanking gap.
  localparam logic [1:0]       SLOT_ENTRY = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
  localparam logic [CNT_W-1:0] SLOT_LD    = (BLANK_CYCLES == 0) ? DIV_LD : BLANK_LD;

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             dir_q, dir_d;
  logic             os_q, os_d;
  logic             e_q, e_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             is_terminal;

  cycle_counter #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign is_terminal = dir_q ? (idx_q == 3'd0) : (idx_q == 3'd7);

  // Sequencer: slot timing, index stepping, stop abort and end-of-sweep detection.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dir_d        = dir_q;
    os_d         = os_q;
    done_d       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = DIV_LD;
    if (stop) begin
      state_d = IDLE;
      idx_d   = 3'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_d        = dir ? 3'd7 : 3'd0;
            dir_d        = dir;
            os_d         = one_shot;
            state_d      = SLOT_ENTRY;
            cnt_load     = 1'b1;
            cnt_load_val = SLOT_LD;
          end else begin
            state_d = IDLE;
          end
        end
        BLANK: begin
          if (cnt_zero) begin
            state_d      = DRIVE;
            cnt_load     = 1'b1;
            cnt_load_val = DIV_LD;
          end else begin
            state_d = BLANK;
          end
        end
        DRIVE: begin
          if (cnt_zero) begin
            if (is_terminal && os_q) begin
              state_d = IDLE;
              idx_d   = 3'd0;
              done_d  = 1'b1;
            end else begin
              idx_d        = dir_q ? (idx_q - 3'd1) : (idx_q + 3'd1);
              state_d      = SLOT_ENTRY;
              cnt_load     = 1'b1;
              cnt_load_val = SLOT_LD;
            end
          end else begin
            state_d = DRIVE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    busy_d = (state_d != IDLE);
    sel_d  = (state_d == IDLE) ? 3'd0 : idx_d;
`ifdef SCAN_SKIP_MASK_EN
    e_d    = (state_d == DRIVE) && !skip_mask[idx_d];
`else
    e_d    = (state_d == DRIVE);
`endif
  end

  // State, latched scan mode and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      dir_q   <= 1'b0;
      os_q    <= 1'b0;
      e_q     <= 1'b0;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      os_q    <= os_d;
      e_q     <= e_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign e    = e_q;
  assign a    = sel_q[2];
  assign b    = sel_q[1];
  assign c    = sel_q[0];
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Directed bench for decoder_scan_driver. Main instance uses DIV=4, BLANK_CYCLES=1;
// a second instance with DIV=2, BLANK_CYCLES=0 covers the no-gap path.
// Cycle k is the interval after rising edge k; start is driven in cycle 0.
module tb_decoder_scan_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic start, stop, dir, one_shot;
  logic [7:0] skip_mask;
  logic [7:0] mask_eff;
  logic e, a, b, c, busy, done;
  logic e0, a0, b0, c0, busy0, done0;
  logic [5:0] vec, vec0;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  always #5 clk = ~clk;

  decoder_scan_driver #(.DIV(4), .BLANK_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef SCAN_SKIP_MASK_EN
    .skip_mask(skip_mask),
`endif
    .start(start), .stop(stop), .dir(dir), .one_shot(one_shot),
    .e(e), .a(a), .b(b), .c(c), .busy(busy), .done(done)
  );

  decoder_scan_driver #(.DIV(2), .BLANK_CYCLES(0)) u_dut_nb (
    .clk(clk), .rst_n(rst_n),
`ifdef SCAN_SKIP_MASK_EN
    .skip_mask(skip_mask),
`endif
    .start(start), .stop(stop), .dir(dir), .one_shot(one_shot),
    .e(e0), .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0)
  );

  assign vec  = {busy, done, e, a, b, c};
  assign vec0 = {busy0, done0, e0, a0, b0, c0};

`ifdef SCAN_SKIP_MASK_EN
  assign mask_eff = skip_mask;
`else
  assign mask_eff = 8'h00;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {busy,done,e,a,b,c} in cycle k of a scan started in cycle 0.
  function automatic logic [5:0] exp_vec(input int k, input bit down, input bit os,
                                         input int div, input int blank);
    int t, per, slot, phase;
    logic [2:0] sel;
    logic en;
    t   = k - 1;
    per = div + blank;
    if (os && t >= 8 * per) return (t == 8 * per) ? 6'b010000 : 6'b000000;
    slot  = (t / per) % 8;
    phase = t % per;
    sel   = down ? 3'(7 - slot) : 3'(slot);
    en    = (phase >= blank) && !mask_eff[sel];
    return {1'b1, 1'b0, en, sel};
  endfunction

  // Start a scan and check n cycles; inputs are flipped afterwards to show they are latched.
  task automatic run_scan(input bit down, input bit os, input int n,
                          input int repulse_k, input bit chk_nb);
    ndone    = 0;
    start    = 1'b1;
    dir      = down;
    one_shot = os;
    for (int k = 1; k <= n; k++) begin
      step();
      start    = (k == repulse_k);
      dir      = ~down;
      one_shot = ~os;
      check("scan", {26'd0, vec}, {26'd0, exp_vec(k, down, os, 4, 1)});
      if (chk_nb) check("scan_noblank", {26'd0, vec0}, {26'd0, exp_vec(k, down, os, 2, 0)});
      if (done) ndone++;
    end
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dir = 1'b0; one_shot = 1'b0;
    skip_mask = 8'h00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Idle after reset with no start.
    for (int i = 0; i < 20; i++) begin
      step();
      check("reset_idle", {26'd0, vec}, 32'd0);
      check("reset_idle_nb", {26'd0, vec0}, 32'd0);
    end

    // One-shot upward sweep, both instances; done exactly once.
`ifdef SCAN_SKIP_MASK_EN
    skip_mask = 8'h0A;
`endif
    run_scan(1'b0, 1'b1, 46, 0, 1'b1);
    check("done_once", ndone, 32'd1);
    skip_mask = 8'h00;

    // Continuous downward scan wraps without done; start re-pulse with dir flipped ignored.
    run_scan(1'b1, 1'b0, 90, 23, 1'b0);
    check("no_done_wrap", ndone, 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_after_wrap", {26'd0, vec}, 32'd0);

    // Stop during DRIVE of slot 3, then a new start restarts from slot 0.
    run_scan(1'b0, 1'b0, 18, 0, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_idle", {26'd0, vec}, 32'd0);
    step();
    check("stop_hold", {26'd0, vec}, 32'd0);
    run_scan(1'b0, 1'b0, 8, 0, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_idle2", {26'd0, vec}, 32'd0);

    // Asynchronous reset between edges while e is high.
    run_scan(1'b0, 1'b0, 3, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {26'd0, vec}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("after_rst_idle", {26'd0, vec}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_scan_driver.md
Name: decoder_scan_driver

Overview:
- Sequential driver for the downstream 3-to-8 decoder: generates its enable `e` and select bits `a`, `b`, `c` (`a` = MSB).
- Steps through all eight decoder outputs in turn, either continuously or as a single sweep.
- Inserts a blanking gap (`e` = 0) at every select change so no decoder output glitches or ghosts.
- Sits directly upstream of the decoder; its outputs wire one-to-one onto the decoder's e/a/b/c inputs.

Parameters:
- DIV, 4, clock cycles `e` is held high per slot (>= 1)
- BLANK_CYCLES, 1, clock cycles `e` is held low before each slot (>= 0)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin scanning; level-sampled, acted on only in IDLE
- stop  input  1  abort scanning; acted on in any state
- dir  input  1  0 = count 0→7, 1 = count 7→0; sampled only when start is accepted
- one_shot  input  1  1 = single sweep then stop, 0 = wrap forever; sampled only when start is accepted
- e  output  1  decoder enable
- a  output  1  select bit 2 (MSB)
- b  output  1  select bit 1
- c  output  1  select bit 0
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at the end of a one-shot sweep

Behaviour:
- Interface: one clock (`clk`); reset `rst_n` is asynchronous and active-low.
- All outputs are registered.
- Reset values: state = IDLE, idx = 0, e = 0, {a,b,c} = 3'b000, busy = 0, done = 0.
- Internal registers:
  - idx[2:0]
  - cnt, wide enough for max(DIV, BLANK_CYCLES)
  - latched dir_q and os_q
- IDLE: e = 0, {a,b,c} = 0.
  - start = 1 and stop = 0 → idx = dir ? 7 : 0; latch dir and one_shot.
  - Next state is BLANK, or DRIVE directly if BLANK_CYCLES = 0.
- BLANK: e = 0, {a,b,c} = idx. Lasts exactly BLANK_CYCLES cycles, then DRIVE.
- DRIVE: e = 1, {a,b,c} = idx. Lasts exactly DIV cycles. On its last cycle:
  - Terminal slot (idx = 7 when counting up, idx = 0 when counting down) with os_q = 1 → go to IDLE and pulse done = 1 in the same cycle the IDLE outputs appear.
  - Otherwise → idx = idx ± 1 modulo 8 (7→0 and 0→7 wrap) and go to BLANK/DRIVE as above.
- Stability rule: {a,b,c} changes only on the cycle entering BLANK, or entering DRIVE when BLANK_CYCLES = 0. The select never changes while e = 1, except when BLANK_CYCLES = 0.
- Latency: start sampled at edge N → busy = 1 after edge N; e rises after edge N + BLANK_CYCLES.
- Slot period: BLANK_CYCLES + DIV cycles. A full sweep takes 8 × (BLANK_CYCLES + DIV) cycles.
- stop has priority over start. Asserting stop in any state → IDLE on the next edge:
  - e = 0, idx = 0, done stays 0.
- start while busy is ignored; dir and one_shot changes mid-scan are ignored.
- Reset asserted mid-scan: outputs go to their reset values immediately (asynchronous). Scanning resumes only after a fresh start.

Optional Feature:
- Macro: SCAN_SKIP_MASK_EN.
- When defined:
  - Adds input `skip_mask[7:0]`, sampled every cycle.
  - In DRIVE, e = ~skip_mask[idx]. The slot still consumes its full DIV cycles, so timing is unchanged.
  - done and busy are unaffected.
- When undefined: the port is absent and e = 1 throughout DRIVE.

Decomposition:
- Shared package `decoder_pkg`:
  - state encoding localparams IDLE = 2'd0, BLANK = 2'd1, DRIVE = 2'd2
  - constant NUM_OUTPUTS = 8
  - constant SEL_W = 3
- No sub-module is needed beyond an optional generic `cycle_counter` (load / decrement / zero flag), reused for both the BLANK and DRIVE timers.

Test Plan:
- Reset release, no start:
  - e = 0, {a,b,c} = 0, busy = 0 held for 20 cycles.
- DIV = 4, BLANK = 1, dir = 0, one_shot = 1, start pulse at cycle 0:
  - e high for cycles 2–5 with abc = 000, then 7–10 with abc = 001, … , 37–40 with abc = 111.
  - done = 1 exactly once, at cycle 41; busy = 0 from cycle 41.
- dir = 1, one_shot = 0:
  - Sequence 111, 110, … , 000, 111: wraps without a done pulse.
  - Chained with the decoder, exactly one of d0–d7 is high during each DRIVE window and none is high during BLANK.
- stop asserted during DRIVE of slot 3:
  - Next cycle e = 0, busy = 0, abc = 000, done = 0.
  - A new start restarts from slot 0.
- start re-pulsed mid-scan with dir toggled:
  - Sequence continues unchanged; no restart.
- rst_n dropped asynchronously mid-DRIVE (between clock edges):
  - e falls without waiting for clk.
- With SCAN_SKIP_MASK_EN and skip_mask = 8'h0A:
  - e stays 0 during the slots with abc = 001 and abc = 011; slot timing is identical to the unmasked run.
